counter_sequencer: RTL and testbench

- Sequences one up-counting and one down-counting counter_fsm pair on the divided clock. It issues single-cycle go pulses, waits for each counter's done, and inserts programmable dwell at the turnaround points.
- Selects which counter output drives the LEDs.
- Adds start/stop control, one-shot or continuous looping, a completed-cycle count and a per-phase watchdog that flags a stalled counter.
- Sits between the clock divider / counter instances and the top-level LED outputs.

---
 rtl/counter_sequencer.sv | 176 +++++++++++++++++
 tb/tb_counter_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Up/down counter sequencer: issues go pulses, waits for done, dwells at the
// turnarounds, and handles start/stop, looping, cycle counting and a watchdog.
module counter_sequencer #(
    parameter int WIDTH     = 4,
    parameter int DWELL     = 2,
    parameter int TIMEOUT   = 31,
    parameter int CYC_WIDTH = 8
) (
    input  logic                 div_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop_en,
    input  logic                 err_clr,
    input  logic [WIDTH-1:0]     up_out,
    input  logic                 up_done,
    input  logic [WIDTH-1:0]     down_out,
    input  logic                 down_done,
    output logic                 up_go,
    output logic                 down_go,
    output logic [WIDTH-1:0]     led,
    output logic                 busy,
    output logic                 seq_done,
    output logic                 err,
    output logic [CYC_WIDTH-1:0] cycles
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_GO_UP     = 3'd1;
    localparam logic [2:0] S_WAIT_UP   = 3'd2;
    localparam logic [2:0] S_DWELL_TOP = 3'd3;
    localparam logic [2:0] S_GO_DOWN   = 3'd4;
    localparam logic [2:0] S_WAIT_DOWN = 3'd5;
    localparam logic [2:0] S_DWELL_BOT = 3'd6;
    localparam logic [2:0] S_ERROR     = 3'd7;

    localparam int TW = $clog2(TIMEOUT + 2);
    localparam int DW = $clog2(DWELL + 2);
    // Timer holds the number of WAIT cycles already spent, so the last
    // permitted cycle is the one where it reads TIMEOUT-1.
    localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [DW-1:0] DWELL_LAST = DW'((DWELL > 0) ? DWELL - 1 : 0);

    logic [2:0]           r_state;
    logic                 r_up_go;
    logic                 r_down_go;
    logic [WIDTH-1:0]     r_led;
    logic                 r_busy;
    logic                 r_seq_done;
    logic                 r_err;
    logic [CYC_WIDTH-1:0] r_cycles;
    logic                 r_stop_req;
    logic [TW-1:0]        r_timer;
    logic [DW-1:0]        r_dwell;

    logic [2:0] w_state_nxt;
    logic       w_seq_done_nxt;
    logic       w_cyc_inc;
    logic       w_tmo;
    logic       w_dwell_end;
    logic       w_stop_any;
    logic       w_busy_now;

    assign w_tmo       = (TIMEOUT != 0) && (r_timer == TMO_LAST);
    assign w_dwell_end = (r_dwell == DWELL_LAST);
    assign w_stop_any  = r_stop_req | stop;
    assign w_busy_now  = (r_state != S_IDLE) && (r_state != S_ERROR);

    always_comb begin
        w_state_nxt    = r_state;
        w_seq_done_nxt = 1'b0;
        w_cyc_inc      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !stop)
                    w_state_nxt = S_GO_UP;
            end
            S_GO_UP:   w_state_nxt = S_WAIT_UP;
            S_WAIT_UP: begin
                if (up_done)
                    w_state_nxt = (DWELL == 0) ? S_GO_DOWN : S_DWELL_TOP;
                else if (w_tmo)
                    w_state_nxt = S_ERROR;
            end
            S_DWELL_TOP: begin
                if (w_dwell_end)
                    w_state_nxt = S_GO_DOWN;
            end
            S_GO_DOWN: w_state_nxt = S_WAIT_DOWN;
            S_WAIT_DOWN: begin
                if (down_done) begin
                    w_cyc_inc = 1'b1;
                    if (loop_en && !w_stop_any) begin
                        w_state_nxt = (DWELL == 0) ? S_GO_UP : S_DWELL_BOT;
                    end else begin
                        w_state_nxt    = S_IDLE;
                        w_seq_done_nxt = 1'b1;
                    end
                end else if (w_tmo) begin
                    w_state_nxt = S_ERROR;
                end
            end
            S_DWELL_BOT: begin
                if (w_dwell_end) begin
                    if (w_stop_any) begin
                        w_state_nxt    = S_IDLE;
                        w_seq_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_GO_UP;
                    end
                end
            end
            S_ERROR: begin
                if (err_clr)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge div_clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_up_go    <= 1'b0;
            r_down_go  <= 1'b0;
            r_led      <= '0;
            r_busy     <= 1'b0;
            r_seq_done <= 1'b0;
            r_err      <= 1'b0;
            r_cycles   <= '0;
            r_stop_req <= 1'b0;
            r_timer    <= '0;
            r_dwell    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_up_go    <= (w_state_nxt == S_GO_UP);
            r_down_go  <= (w_state_nxt == S_GO_DOWN);
            r_busy     <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_ERROR);
            r_err      <= (w_state_nxt == S_ERROR);
            r_seq_done <= w_seq_done_nxt;

            if (w_cyc_inc && (r_cycles != '1))
                r_cycles <= r_cycles + CYC_WIDTH'(1);

            if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_ERROR))
                r_stop_req <= 1'b0;
            else if (stop && w_busy_now)
                r_stop_req <= 1'b1;

            if ((r_state == S_GO_UP) || (r_state == S_GO_DOWN))
                r_timer <= '0;
            else if ((r_state == S_WAIT_UP) || (r_state == S_WAIT_DOWN))
                r_timer <= r_timer + TW'(1);

            if ((r_state == S_DWELL_TOP) || (r_state == S_DWELL_BOT))
                r_dwell <= w_dwell_end ? '0 : r_dwell + DW'(1);
            else
                r_dwell <= '0;

            if (r_state == S_WAIT_UP)
                r_led <= up_out;
            else if (r_state == S_WAIT_DOWN)
                r_led <= down_out;
        end
    end

    assign up_go    = r_up_go;
    assign down_go  = r_down_go;
    assign led      = r_led;
    assign busy     = r_busy;
    assign seq_done = r_seq_done;
    assign err      = r_err;
    assign cycles   = r_cycles;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench: default sequencer (dut 0) and a DWELL=0, CYC_WIDTH=2 one (dut 1),
// each driven by a behavioural 0..15 up / 15..0 down counter model.
module tb_counter_sequencer;

    logic            div_clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      start_v = '0, stop_v = '0, loop_v = '0, clr_v = '0;
    logic [1:0]      stall_v = '0, inj_v = '0;
    logic [1:0]      ug, dg, busy_v, sd_v, err_v, u_done, d_done;
    logic [1:0][3:0] led_v, u_cnt, d_cnt;
    logic [1:0]      u_run, d_run;
    logic [7:0]      cyc0;
    logic [1:0]      cyc1;
    int              n_checks = 0;
    int              n_err = 0;

    always #5 div_clk = ~div_clk;

    always @(posedge div_clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                u_run[i] <= 1'b0; u_cnt[i] <= 4'd0;
                d_run[i] <= 1'b0; d_cnt[i] <= 4'd15;
            end else begin
                if (ug[i]) begin
                    u_run[i] <= 1'b1; u_cnt[i] <= 4'd0;
                end else if (u_run[i]) begin
                    if (u_cnt[i] == 4'd15) u_run[i] <= 1'b0;
                    else u_cnt[i] <= u_cnt[i] + 4'd1;
                end
                if (dg[i]) begin
                    d_run[i] <= 1'b1; d_cnt[i] <= 4'd15;
                end else if (d_run[i]) begin
                    if (d_cnt[i] == 4'd0) d_run[i] <= 1'b0;
                    else d_cnt[i] <= d_cnt[i] - 4'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_mdl
        assign u_done[g] = (u_run[g] && (u_cnt[g] == 4'd15) && !stall_v[g]) || inj_v[g];
        assign d_done[g] = d_run[g] && (d_cnt[g] == 4'd0);
    end

    counter_sequencer #(.WIDTH(4), .DWELL(2), .TIMEOUT(31), .CYC_WIDTH(8)) dut0 (
        .div_clk(div_clk), .rst(rst), .start(start_v[0]), .stop(stop_v[0]),
        .loop_en(loop_v[0]), .err_clr(clr_v[0]), .up_out(u_cnt[0]), .up_done(u_done[0]),
        .down_out(d_cnt[0]), .down_done(d_done[0]), .up_go(ug[0]), .down_go(dg[0]),
        .led(led_v[0]), .busy(busy_v[0]), .seq_done(sd_v[0]), .err(err_v[0]), .cycles(cyc0));

    counter_sequencer #(.WIDTH(4), .DWELL(0), .TIMEOUT(31), .CYC_WIDTH(2)) dut1 (
        .div_clk(div_clk), .rst(rst), .start(start_v[1]), .stop(stop_v[1]),
        .loop_en(loop_v[1]), .err_clr(clr_v[1]), .up_out(u_cnt[1]), .up_done(u_done[1]),
        .down_out(d_cnt[1]), .down_done(d_done[1]), .up_go(ug[1]), .down_go(dg[1]),
        .led(led_v[1]), .busy(busy_v[1]), .seq_done(sd_v[1]), .err(err_v[1]), .cycles(cyc1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge div_clk);
    endtask

    function automatic bit cond(input int s);
        case (s)
            0: return ug[0];
            1: return sd_v[0];
            2: return ug[1];
            3: return sd_v[1];
            default: return dg[1];
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string tag);
        int n = 0;
        while (!cond(sel) && n < budget) begin
            step(1);
            n++;
        end
        n_checks++;
        assert (cond(sel)) else begin
            n_err++;
            $error("FAIL %s: event not seen after %0d cycles, observed 0 expected 1", tag, n);
        end
    endtask

    initial begin
        int cnt_a, cnt_b;
        // reset state
        step(3);
        chk("rst_up_go", ug[0], 0);
        chk("rst_down_go", dg[0], 0);
        chk("rst_led", led_v[0], 0);
        chk("rst_busy", busy_v[0], 0);
        chk("rst_err", err_v[0], 0);
        chk("rst_cycles", cyc0, 0);
        rst = 1'b0;

        // one-shot up+down cycle
        start_v[0] = 1'b1;
        step(1);
        chk("t1_up_go", ug[0], 1);
        chk("t1_busy", busy_v[0], 1);
        start_v[0] = 1'b0;
        step(6);
        chk("t1_up_go_drop", ug[0], 0);
        chk("t1_led_k5", led_v[0], 4);
        step(11);
        chk("t1_led_top1", led_v[0], 15);
        step(1);
        chk("t1_led_top2", led_v[0], 15);
        chk("t1_no_down_go", dg[0], 0);
        step(1);
        chk("t1_down_go", dg[0], 1);
        step(1);
        chk("t1_down_go_drop", dg[0], 0);
        step(6);
        chk("t1_led_m6", led_v[0], 10);
        step(10);
        chk("t1_seq_done", sd_v[0], 1);
        chk("t1_cycles", cyc0, 1);
        chk("t1_busy_end", busy_v[0], 0);
        chk("t1_led_end", led_v[0], 0);
        step(1);
        chk("t1_seq_done_drop", sd_v[0], 0);

        // looping, stop requested mid WAIT_UP of the fourth cycle
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        loop_v[0] = 1'b1;
        start_v[0] = 1'b1;
        step(1);
        start_v[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            wait_for(0, 60, "t2_loop_up_go");
        end
        chk("t2_cycles_3", cyc0, 3);
        step(5);
        stop_v[0] = 1'b1;
        step(1);
        stop_v[0] = 1'b0;
        wait_for(1, 100, "t2_seq_done");
        chk("t2_cycles_4", cyc0, 4);
        chk("t2_busy", busy_v[0], 0);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (ug[0]) cnt_a++;
            if (sd_v[0]) cnt_b++;
        end
        chk("t2_no_more_up_go", cnt_a, 0);
        chk("t2_single_seq_done", cnt_b, 0);
        loop_v[0] = 1'b0;

        // watchdog on a stalled up counter
        stall_v[0] = 1'b1;
        start_v[0] = 1'b1;
        step(1);
        start_v[0] = 1'b0;
        chk("t3_up_go", ug[0], 1);
        step(31);
        chk("t3_err_k30", err_v[0], 0);
        chk("t3_busy_k30", busy_v[0], 1);
        step(1);
        chk("t3_err", err_v[0], 1);
        chk("t3_busy_err", busy_v[0], 0);
        chk("t3_down_go", dg[0], 0);
        start_v[0] = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (ug[0] || dg[0]) cnt_a++;
        end
        chk("t3_go_in_error", cnt_a, 0);
        chk("t3_err_held", err_v[0], 1);
        start_v[0] = 1'b0;
        step(1);
        clr_v[0] = 1'b1;
        step(1);
        clr_v[0] = 1'b0;
        chk("t3_err_clr", err_v[0], 0);
        chk("t3_seq_done_clr", sd_v[0], 0);
        chk("t3_cycles_held", cyc0, 4);

        // done coinciding with the last permitted WAIT_UP cycle
        start_v[0] = 1'b1;
        step(1);
        start_v[0] = 1'b0;
        chk("t4_up_go", ug[0], 1);
        step(31);
        inj_v[0] = 1'b1;
        step(1);
        inj_v[0] = 1'b0;
        stall_v[0] = 1'b0;
        chk("t4_no_err", err_v[0], 0);
        chk("t4_busy", busy_v[0], 1);
        wait_for(1, 100, "t4_seq_done");
        chk("t4_cycles", cyc0, 5);

        // DWELL=0: down_go right after the up_done cycle
        start_v[1] = 1'b1;
        step(1);
        start_v[1] = 1'b0;
        chk("t5_up_go", ug[1], 1);
        step(16);
        chk("t5_down_go_k15", dg[1], 0);
        step(1);
        chk("t5_down_go", dg[1], 1);
        wait_for(3, 40, "t5_seq_done");
        chk("t5_cycles", cyc1, 1);
        start_v[1] = 1'b1;
        stop_v[1] = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (ug[1] || busy_v[1]) cnt_a++;
        end
        chk("t5_start_stop_idle", cnt_a, 0);
        start_v[1] = 1'b0;
        stop_v[1] = 1'b0;

        // saturating 2-bit cycle counter, then reset mid WAIT_DOWN
        loop_v[1] = 1'b1;
        start_v[1] = 1'b1;
        step(1);
        start_v[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            wait_for(2, 60, "t6_loop_up_go");
        end
        chk("t6_cycles_sat", cyc1, 3);
        wait_for(4, 40, "t6_down_go");
        step(5);
        chk("t6_busy_pre", busy_v[1], 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_up_go", ug[1], 0);
        chk("t6_rst_down_go", dg[1], 0);
        chk("t6_rst_led", led_v[1], 0);
        chk("t6_rst_busy", busy_v[1], 0);
        chk("t6_rst_seq_done", sd_v[1], 0);
        chk("t6_rst_err", err_v[1], 0);
        chk("t6_rst_cycles", cyc1, 0);
        chk("t6_rst_cycles0", cyc0, 0);
        step(2);
        rst = 1'b0;
        loop_v[1] = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
